// File: rtl/mips_mul_pkg.sv
// ---------------------------------------------------------------------------
// mips_mul_pkg
// Shared definitions for the HI/LO multiply unit: the sequencer state
// encoding, the default operand width and the matching iteration-counter
// width.
// ---------------------------------------------------------------------------
package mips_mul_pkg;

    // Sequencer states: waiting for work, shift-add iterations, sign fix-up
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

    // Default operand width (HI and LO are each this wide)
    localparam int MUL_WIDTH = 32;

    // Counter width needed to index MUL_WIDTH iterations
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

endpackage : mips_mul_pkg

// File: rtl/add32_cla.sv
// ---------------------------------------------------------------------------
// add32_cla
// WIDTH-bit adder built from WIDTH/4 chained 4-bit carry-lookahead slices.
// Inside each slice the carries are computed in parallel from generate and
// propagate terms; between slices the carry ripples slice to slice.
// WIDTH must be a multiple of 4.
//
// Ports
//   i_a    in  WIDTH  addend A
//   i_b    in  WIDTH  addend B
//   i_cin  in  1      carry into bit 0
//   o_sum  out WIDTH  A + B + cin (low WIDTH bits)
//   o_cout out 1      carry out of the top slice
// ---------------------------------------------------------------------------
module add32_cla #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int SLICES = WIDTH / 4;

    // w_slice_c[s] is the carry entering slice s
    logic [SLICES:0] w_slice_c;

    assign w_slice_c[0] = i_cin;

    generate
        for (genvar s = 0; s < SLICES; s++) begin : g_slice
            logic [3:0] w_g;
            logic [3:0] w_p;
            logic [3:0] w_c;

            assign w_g = i_a[4*s +: 4] & i_b[4*s +: 4];
            assign w_p = i_a[4*s +: 4] ^ i_b[4*s +: 4];

            // Lookahead carries into each bit of the slice
            assign w_c[0] = w_slice_c[s];
            assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
            assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
            assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                          | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);

            assign w_slice_c[s+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

            assign o_sum[4*s +: 4] = w_p ^ w_c;
        end
    endgenerate

    assign o_cout = w_slice_c[SLICES];

endmodule : add32_cla

// File: rtl/hilo_mult_unit.sv
// ---------------------------------------------------------------------------
// hilo_mult_unit
// Iterative MULT/MULTU unit for the EX stage. Operands are reduced to
// magnitudes, multiplied by a shift-add loop (one multiplier bit per cycle)
// and the sign is applied in a final fix-up cycle. The unit also owns the
// architectural HI/LO registers, which MTHI/MTLO write while idle.
//
// Ports
//   i_clk        in  1      rising-edge clock
//   i_rst        in  1      synchronous active-high reset
//   i_start      in  1      launch a multiply (only accepted in IDLE)
//   i_is_signed  in  1      1 = MULT, 0 = MULTU
//   i_op_a       in  WIDTH  multiplicand (rs)
//   i_op_b       in  WIDTH  multiplier (rt)
//   i_mthi_we    in  1      write i_wdata into HI (IDLE, no start)
//   i_mtlo_we    in  1      write i_wdata into LO (IDLE, no start)
//   i_wdata      in  WIDTH  MTHI/MTLO data
//   o_busy       out 1      multiply in flight
//   o_done       out 1      one-cycle pulse: HI/LO hold the new product
//   o_hi         out WIDTH  HI register
//   o_lo         out WIDTH  LO register
// ---------------------------------------------------------------------------
module hilo_mult_unit
    import mips_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_mthi_we,
    input  logic             i_mtlo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      ONE_CNT    = {{(CW-1){1'b0}}, 1'b1};

    mul_state_t r_state;
    mul_state_t w_next_state;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_count;
    logic             r_neg;
    logic             r_done;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_acc_full;
    logic [2*WIDTH-1:0] w_neg_prod;
    logic               w_last;

    // Magnitude of a signed operand is ~x + 1. The most negative value maps
    // onto itself, which is the correct magnitude when read as unsigned.
    assign w_mag_a = (i_is_signed && i_op_a[WIDTH-1]) ? (~i_op_a + ONE_W) : i_op_a;
    assign w_mag_b = (i_is_signed && i_op_b[WIDTH-1]) ? (~i_op_b + ONE_W) : i_op_b;

    // Multiplicand is added only when the current multiplier LSB is set
    assign w_addend = r_mplier[0] ? r_mcand : '0;

    add32_cla #(
        .WIDTH (WIDTH)
    ) u_acc_add (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    // The multiplier register doubles as the low half of the accumulator
    // as it is shifted out, so {acc_hi, mplier} is the full product.
    assign w_acc_full = {r_acc_hi, r_mplier};
    assign w_neg_prod = ~w_acc_full + ONE_2W;
    assign w_last     = (r_count == LAST_COUNT);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed WIDTH iterations, no early exit on zero
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (i_start) w_next_state = CALC;
            CALC: if (w_last)  w_next_state = FIX;
            FIX:               w_next_state = IDLE;
            default:           w_next_state = IDLE;
        endcase
    end

    // Datapath and HI/LO. Start has priority over MTHI/MTLO in IDLE, and
    // HI/LO are touched only in FIX so partial products never show.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc_hi <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_acc_hi <= '0;
                        r_count  <= '0;
                        r_neg    <= i_is_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
                    end else begin
                        if (i_mthi_we) r_hi <= i_wdata;
                        if (i_mtlo_we) r_lo <= i_wdata;
                    end
                end
                CALC: begin
                    // Shift {carry, sum, mplier} right by one
                    r_acc_hi <= {w_carry, w_sum[WIDTH-1:1]};
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + ONE_CNT;
                end
                FIX: begin
                    {r_hi, r_lo} <= r_neg ? w_neg_prod : w_acc_full;
                    r_done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule : hilo_mult_unit

// File: tb/tb_hilo_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_mult_unit
// Directed self-checking bench for the HI/LO multiply unit. Expected values
// are hand-computed constants; the bench keeps its own copy of HI/LO to check
// that they hold steady while a multiply is in flight.
// ---------------------------------------------------------------------------
module tb_hilo_mult_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        isSigned;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        mthiWe;
    logic        mtloWe;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total;
    int          bad;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    hilo_mult_unit #(
        .WIDTH (32)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_is_signed (isSigned),
        .i_op_a      (opA),
        .i_op_b      (opB),
        .i_mthi_we   (mthiWe),
        .i_mtlo_we   (mtloWe),
        .i_wdata     (wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_hi        (hi),
        .o_lo        (lo)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives every input of the unit for the current cycle
    task automatic applyStimulus(input logic st, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic hw, input logic lw,
                                 input logic [31:0] wd);
        start    = st;
        isSigned = sgn;
        opA      = a;
        opB      = b;
        mthiWe   = hw;
        mtloWe   = lw;
        wdata    = wd;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Launches a multiply in the current cycle (T) and follows it to T+35.
    // actKind 1: second MULT 9x9 start at T+actCycle; 2: MTLO at T+actCycle.
    task automatic runMul(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic hw, input logic lw,
                          input logic [31:0] expHi, input logic [31:0] expLo,
                          input int actCycle, input int actKind);
        int busyErr = 0;
        int doneErr = 0;
        int holdErr = 0;
        applyStimulus(1'b1, sgn, a, b, hw, lw, 32'h5555_AAAA);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            idleInputs();
            if (k == actCycle && actKind == 1)
                applyStimulus(1'b1, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 32'h0);
            if (k == actCycle && actKind == 2)
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
            if (k <= 33) begin
                if (busy !== 1'b1) busyErr++;
                if (done !== 1'b0) doneErr++;
                if (hi !== modelHi || lo !== modelLo) holdErr++;
            end
        end
        checkOutput({tag, "_busyWindow"}, 64'(busyErr), 64'd0);
        checkOutput({tag, "_noEarlyDone"}, 64'(doneErr), 64'd0);
        checkOutput({tag, "_hiloHeld"}, 64'(holdErr), 64'd0);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "_busyLow"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, "_product"}, {hi, lo}, {expHi, expLo});
        modelHi = expHi;
        modelLo = expLo;
        @(posedge clk); #1;
        checkOutput({tag, "_donePulse"}, {63'd0, done}, 64'd0);
    endtask

    // MTHI/MTLO in IDLE; result visible next cycle
    task automatic writeHiLo(input string tag, input logic hw, input logic lw,
                             input logic [31:0] wd);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, hw, lw, wd);
        @(posedge clk); #1;
        idleInputs();
        if (hw) modelHi = wd;
        if (lw) modelLo = wd;
        checkOutput({tag, "_hilo"}, {hi, lo}, {modelHi, modelLo});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        modelHi = 32'h0;
        modelLo = 32'h0;
        rst     = 1'b1;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);

        // Unsigned and signed products
        runMul("multu_3x5", 1'b0, 32'd3, 32'd5, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_000F, 0, 0);
        runMul("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        runMul("mult_m2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0);
        runMul("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
               32'h4000_0000, 32'h0000_0000, 0, 0);
        runMul("mult_maxxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0,
               32'hC000_0000, 32'h8000_0000, 0, 0);
        runMul("mult_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_0001, 0, 0);
        runMul("multu_zero", 1'b0, 32'h0, 32'h0000_1234, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_0000, 0, 0);

        // Second start while busy is ignored
        runMul("mult_7x7_restart", 1'b1, 32'd7, 32'd7, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_0031, 10, 1);

        // MTHI in IDLE, then MTLO during a multiply is discarded
        writeHiLo("mthi", 1'b1, 1'b0, 32'h1234_5678);
        runMul("multu_2x2_mtlo", 1'b0, 32'd2, 32'd2, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_0004, 5, 2);

        // Both writes together, then start beating same-cycle writes
        writeHiLo("mthi_mtlo", 1'b1, 1'b1, 32'hA5A5_A5A5);
        runMul("start_wins", 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1,
               32'h0000_0001, 32'h0000_0000, 0, 0);

        // Reset mid-calculation aborts, then a fresh start completes
        writeHiLo("pre_rst", 1'b1, 1'b1, 32'hC3C3_C3C3);
        applyStimulus(1'b1, 1'b0, 32'd6, 32'd7, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            idleInputs();
            if (k == 10) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        modelHi = 32'h0;
        modelLo = 32'h0;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        runMul("multu_6x7_after_rst", 1'b0, 32'd6, 32'd7, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_002A, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hilo_mult_unit
